// File: rtl/cdf_builder.sv
// Histogram-to-CDF scan: reads 256 bins of one histogram bank, writes running sums to the CDF bank.
// Define CDF_CLEAR_HIST_EN to zero each histogram bin right after it has been read.
module cdf_builder #(
  parameter int BINS    = 256,
  parameter int ADDR_W  = 8,
  parameter int COUNT_W = 20
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               bank,
  output logic               hist_rd,
  output logic [ADDR_W:0]    hist_addr,
  input  logic [COUNT_W-1:0] hist_rdata,
  output logic               hist_we,
  output logic [ADDR_W:0]    hist_waddr,
  output logic               cdf_we,
  output logic [ADDR_W:0]    cdf_waddr,
  output logic [COUNT_W-1:0] cdf_wdata,
  output logic [COUNT_W-1:0] Cdf_Min,
  output logic               cdf_valid,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BINS - 1);

  state_t              state;
  state_t              state_next;
  logic                accept;
  logic                finish;
  logic                last_wr;

  logic                bank_q;
  logic [ADDR_W-1:0]   rd_idx;
  logic                rd_valid;
  logic [ADDR_W-1:0]   rd_bin;
  logic [COUNT_W-1:0]  sum_q;
  logic [COUNT_W-1:0]  sum_next;
  logic [COUNT_W-1:0]  min_acc;
  logic                found;

  assign hist_rd   = (state == SCAN);
  assign hist_addr = {bank_q, rd_idx};
  assign busy      = (state != IDLE);
  assign sum_next  = sum_q + hist_rdata;
  assign last_wr   = cdf_we && (cdf_waddr[ADDR_W-1:0] == LAST_BIN);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (rd_idx == LAST_BIN) state_next = DRAIN;
      end
      DRAIN: begin
        if (last_wr) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // The completion cycle doubles as a decision point so scans can run back to back.
        if (start) begin
          accept     = 1'b1;
          state_next = SCAN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and all state uses non-blocking assignments.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bank_q    <= 1'b0;
      rd_idx    <= '0;
      rd_valid  <= 1'b0;
      rd_bin    <= '0;
      sum_q     <= '0;
      min_acc   <= '0;
      found     <= 1'b0;
      cdf_we    <= 1'b0;
      cdf_waddr <= '0;
      cdf_wdata <= '0;
      Cdf_Min   <= '0;
      cdf_valid <= 1'b0;
    end else begin
      // Read data lags the strobe by one cycle; carry the bin index alongside it.
      rd_valid  <= hist_rd;
      rd_bin    <= rd_idx;
      cdf_we    <= rd_valid;
      cdf_valid <= finish;

      if (accept) begin
        bank_q <= bank;
        rd_idx <= '0;
      end else if (hist_rd) begin
        rd_idx <= rd_idx + 1'b1;
      end

      if (accept) begin
        sum_q   <= '0;
        min_acc <= '0;
        found   <= 1'b0;
      end else if (rd_valid) begin
        sum_q     <= sum_next;
        cdf_waddr <= {bank_q, rd_bin};
        cdf_wdata <= sum_next;
        if (!found && (sum_next != '0)) begin
          found   <= 1'b1;
          min_acc <= sum_next;
        end
      end

      if (finish) Cdf_Min <= min_acc;
    end
  end

`ifdef CDF_CLEAR_HIST_EN
  // The clear write trails the read by one cycle, on the RAM's separate write port.
  assign hist_we    = rd_valid;
  assign hist_waddr = {bank_q, rd_bin};
`else
  assign hist_we    = 1'b0;
  assign hist_waddr = '0;
`endif

  a_valid_single: assert property (@(posedge clock) disable iff (!reset_n)
    cdf_valid |=> !cdf_valid);
  a_strobe_busy: assert property (@(posedge clock) disable iff (!reset_n)
    (hist_rd || cdf_we) |-> busy);

endmodule
